// File: rtl/cp0_exc_ctrl_pkg.sv
// rtl/cp0_exc_ctrl_pkg.sv - CP0 register numbers, field positions, exception codes and EXL state type
package cp0_exc_ctrl_pkg;

   // "No exception" marker carried down the pipeline
   localparam logic [5:0] EXC_NONE = 6'd0;

   // Exception codes written into Cause.ExcCode
   typedef enum logic [5:0] {
      EXC_INT  = 6'd0,
      EXC_ADEL = 6'd4,
      EXC_ADES = 6'd5,
      EXC_RI   = 6'd10,
      EXC_OV   = 6'd12
   } exc_code_e;

   // CP0 register numbers
   localparam logic [4:0] CP0_SR    = 5'd12;
   localparam logic [4:0] CP0_CAUSE = 5'd13;
   localparam logic [4:0] CP0_EPC   = 5'd14;
   localparam logic [4:0] CP0_PRID  = 5'd15;

   // SR field positions
   localparam int SR_IE_BIT  = 0;
   localparam int SR_EXL_BIT = 1;
   localparam int SR_IM_LO   = 10;
   localparam int SR_IM_HI   = 15;

   // Cause field positions
   localparam int CAUSE_EXC_LO = 2;
   localparam int CAUSE_EXC_HI = 6;
   localparam int CAUSE_IP_LO  = 10;
   localparam int CAUSE_IP_HI  = 15;
   localparam int CAUSE_BD_BIT = 31;

   // NORMAL is EXL=0, HANDLER is EXL=1
   typedef enum logic {
      ST_NORMAL  = 1'b0,
      ST_HANDLER = 1'b1
   } exl_state_e;

   // EPC always holds a word address
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/cp0_exc_ctrl_int_sync.sv
// rtl/cp0_exc_ctrl_int_sync.sv - multi-flop synchronizer for the external interrupt lines
module cp0_exc_ctrl_int_sync #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [STAGES-1:0][WIDTH-1:0] sync_q;
   logic [STAGES-1:0][WIDTH-1:0] sync_d;

   // shift the raw lines one stage deeper every cycle
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
   end

   // synchronizer flops, cleared straight away by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - M-stage CP0 exception/interrupt controller (SR/Cause/EPC/PRId, trap and eret redirect)
module cp0_exc_ctrl
   import cp0_exc_ctrl_pkg::*;
#(
   parameter logic [31:0] HANDLER_PC  = 32'h0000_4180,
   parameter logic [31:0] PRID_VAL    = 32'h2019_0700,
   parameter int          SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic        m_valid,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [5:0]  exccode_m,
   input  logic        eret_m,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        exc_flush,
   output logic        eret_redirect,
   output logic [31:0] redirect_pc,
   output logic        exl_o
);

   exl_state_e  state_q, state_d;
   logic [5:0]  im_q, im_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [4:0]  exccode_q, exccode_d;
   logic [31:0] epc_q, epc_d;
   logic [5:0]  ip;
   logic        exl;
   logic        m_live;
   logic        int_take;
   logic        exc_take;
   logic [31:0] sr_word;
   logic [31:0] cause_word;

   cp0_exc_ctrl_int_sync #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (6)
   ) u_int_sync (
      .clk   (clk),
      .rst_n (reset),
      .din   (hw_int),
      .dout  (ip)
   );

   // trap / eret decision from pre-edge state; reset masks everything so no redirect leaks out
   always_comb begin
      exl           = (state_q == ST_HANDLER);
      m_live        = m_valid & reset;
      int_take      = m_live & ie_q & ~exl & (|(ip & im_q));
      exc_take      = m_live & ~exl & (exccode_m != EXC_NONE);
      exc_flush     = int_take | exc_take;
      eret_redirect = m_live & eret_m & ~exc_flush;
      exl_o         = exl;
      if (exc_flush) begin
         redirect_pc = HANDLER_PC;
      end else if (eret_redirect) begin
         redirect_pc = epc_q;
      end else begin
         redirect_pc = '0;
      end
   end

   // next register state: a trap discards mtc0; an mtc0 to SR overrides the eret EXL clear
   always_comb begin
      state_d   = state_q;
      im_d      = im_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      exccode_d = exccode_q;
      epc_d     = epc_q;
      if (exc_flush) begin
         state_d   = ST_HANDLER;
         bd_d      = bd_m;
         exccode_d = int_take ? 5'(EXC_INT) : exccode_m[4:0];
         epc_d     = word_align(bd_m ? (pc_m - 32'd4) : pc_m);
      end else begin
         if (eret_redirect) begin
            state_d = ST_NORMAL;
         end
         if (cp0_we && (cp0_addr == CP0_SR)) begin
            im_d    = cp0_wdata[SR_IM_HI:SR_IM_LO];
            ie_d    = cp0_wdata[SR_IE_BIT];
            state_d = cp0_wdata[SR_EXL_BIT] ? ST_HANDLER : ST_NORMAL;
         end
         if (cp0_we && (cp0_addr == CP0_EPC)) begin
            epc_d = word_align(cp0_wdata);
         end
      end
   end

   // mfc0 read mux over current register contents (no bypass of a same-cycle mtc0)
   always_comb begin
      sr_word                            = '0;
      sr_word[SR_IM_HI:SR_IM_LO]         = im_q;
      sr_word[SR_EXL_BIT]                = exl;
      sr_word[SR_IE_BIT]                 = ie_q;
      cause_word                         = '0;
      cause_word[CAUSE_BD_BIT]           = bd_q;
      cause_word[CAUSE_IP_HI:CAUSE_IP_LO]   = ip;
      cause_word[CAUSE_EXC_HI:CAUSE_EXC_LO] = exccode_q;
      case (cp0_addr)
         CP0_SR:    cp0_rdata = sr_word;
         CP0_CAUSE: cp0_rdata = cause_word;
         CP0_EPC:   cp0_rdata = epc_q;
         CP0_PRID:  cp0_rdata = PRID_VAL;
         default:   cp0_rdata = '0;
      endcase
   end

   // EXL state register (NORMAL / HANDLER)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_NORMAL;
      end else begin
         state_q <= state_d;
      end
   end

   // SR, Cause and EPC storage
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q      <= '0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         exccode_q <= '0;
         epc_q     <= '0;
      end else begin
         im_q      <= im_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         exccode_q <= exccode_d;
         epc_q     <= epc_d;
      end
   end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - self-checking bench for cp0_exc_ctrl: directed table, reset corners, random vs model
module tb_cp0_exc_ctrl;

   localparam logic [31:0] HPC  = 32'h0000_4180;
   localparam logic [31:0] PRID = 32'h2019_0700;
   localparam int          SYNC = 2;
   localparam bit          Y    = 1'b1;
   localparam bit          N    = 1'b0;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_int;
   logic        m_valid;
   logic [31:0] pc_m;
   logic        bd_m;
   logic [5:0]  exccode_m;
   logic        eret_m;
   logic        cp0_we;
   logic [4:0]  cp0_addr;
   logic [31:0] cp0_wdata;
   logic [31:0] cp0_rdata;
   logic        exc_flush;
   logic        eret_redirect;
   logic [31:0] redirect_pc;
   logic        exl_o;

   cp0_exc_ctrl #(
      .HANDLER_PC  (HPC),
      .PRID_VAL    (PRID),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .hw_int        (hw_int),
      .m_valid       (m_valid),
      .pc_m          (pc_m),
      .bd_m          (bd_m),
      .exccode_m     (exccode_m),
      .eret_m        (eret_m),
      .cp0_we        (cp0_we),
      .cp0_addr      (cp0_addr),
      .cp0_wdata     (cp0_wdata),
      .cp0_rdata     (cp0_rdata),
      .exc_flush     (exc_flush),
      .eret_redirect (eret_redirect),
      .redirect_pc   (redirect_pc),
      .exl_o         (exl_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  hw;
      logic        mv;
      logic [31:0] pc;
      logic        bd;
      logic [5:0]  exc;
      logic        eret;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wd;
      logic        fl;
      logic        er;
      logic        exl;
      logic [31:0] rpc;
      logic [31:0] rd;
   } vec_t;

   vec_t tv[28];
   int   n_vec = 0;
   int   n_bad = 0;

   // reference model: architectural register words plus a delay queue for the interrupt lines
   logic [31:0] m_sr;
   logic [31:0] m_cause;
   logic [31:0] m_epc;
   logic [5:0]  m_sync[$];
   logic [66:0] m_exp;
   logic        m_fl;
   logic        m_er;
   logic        m_int;

   function automatic vec_t mk(input logic [5:0] hw, input logic mv, input logic [31:0] pc,
                               input logic bd, input logic [5:0] exc, input logic eret,
                               input logic we, input logic [4:0] addr, input logic [31:0] wd,
                               input logic fl, input logic er, input logic exl,
                               input logic [31:0] rpc, input logic [31:0] rd);
      vec_t v;
      v.hw = hw; v.mv = mv; v.pc = pc; v.bd = bd; v.exc = exc; v.eret = eret;
      v.we = we; v.addr = addr; v.wd = wd;
      v.fl = fl; v.er = er; v.exl = exl; v.rpc = rpc; v.rd = rd;
      return v;
   endfunction

   function automatic logic [66:0] outs();
      return {exc_flush, eret_redirect, exl_o, redirect_pc, cp0_rdata};
   endfunction

   task automatic model_reset();
      m_sr    = 32'd0;
      m_cause = 32'd0;
      m_epc   = 32'd0;
      m_sync.delete();
      for (int i = 0; i < SYNC; i++) m_sync.push_back(6'd0);
   endtask

   task automatic model_eval();
      logic [5:0]  ip;
      logic        exl;
      logic        en;
      logic [31:0] rd;
      logic [31:0] rpc;
      if (!reset) model_reset();
      ip    = m_sync[0];
      exl   = m_sr[1];
      en    = m_valid && reset;
      m_int = en && m_sr[0] && !exl && ((ip & m_sr[15:10]) != 6'd0);
      m_fl  = m_int || (en && !exl && (exccode_m != 6'd0));
      m_er  = en && eret_m && !m_fl;
      rpc   = m_fl ? HPC : (m_er ? m_epc : 32'd0);
      case (cp0_addr)
         5'd12:   rd = m_sr;
         5'd13:   rd = m_cause | (32'(ip) << 10);
         5'd14:   rd = m_epc;
         5'd15:   rd = PRID;
         default: rd = 32'd0;
      endcase
      m_exp = {m_fl, m_er, exl, rpc, rd};
   endtask

   task automatic model_commit();
      if (!reset) begin
         model_reset();
      end else begin
         if (m_fl) begin
            m_sr[1] = 1'b1;
            m_cause = {bd_m, 31'd0} | (m_int ? 32'd0 : (32'(exccode_m[4:0]) << 2));
            m_epc   = (bd_m ? (pc_m - 32'd4) : pc_m) & 32'hFFFF_FFFC;
         end else begin
            if (m_er) m_sr[1] = 1'b0;
            if (cp0_we && cp0_addr == 5'd12) m_sr = cp0_wdata & 32'h0000_FC03;
            if (cp0_we && cp0_addr == 5'd14) m_epc = cp0_wdata & 32'hFFFF_FFFC;
         end
         m_sync.push_back(hw_int);
         void'(m_sync.pop_front());
      end
   endtask

   task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got flush/eret/exl=%b%b%b pc=%h rdata=%h, want flush/eret/exl=%b%b%b pc=%h rdata=%h",
                  name, act[66], act[65], act[64], act[63:32], act[31:0],
                  exp[66], exp[65], exp[64], exp[63:32], exp[31:0]);
      end
   endtask

   task automatic step(input string name, input bit use_tab, input logic [66:0] exp_tab);
      @(negedge clk);
      model_eval();
      check(name, outs(), use_tab ? exp_tab : m_exp);
      @(posedge clk);
      model_commit();
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, want finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //            hw     mv pc            bd exc    er we addr   wd             fl er exl rpc           rd
      tv[0]  = mk(6'h3f, Y, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0);
      tv[1]  = mk(6'h3f, Y, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0);
      tv[2]  = mk(6'h3f, Y, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0000_fc00);
      tv[3]  = mk(6'h00, N, 32'h0,      N, 6'd0,  N, Y, 5'd12, 32'h0000_fc01, N, N, N, 32'h0,      32'h0);
      tv[4]  = mk(6'h00, N, 32'h0,      N, 6'd0,  N, N, 5'd12, 32'h0,         N, N, N, 32'h0,      32'h0000_fc01);
      tv[5]  = mk(6'h04, Y, 32'h3010,   N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0);
      tv[6]  = mk(6'h04, Y, 32'h3010,   N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0);
      tv[7]  = mk(6'h04, Y, 32'h3010,   N, 6'd0,  N, N, 5'd14, 32'h0,         Y, N, N, HPC,        32'h0);
      tv[8]  = mk(6'h04, Y, 32'h3010,   N, 6'd0,  N, N, 5'd14, 32'h0,         N, N, Y, 32'h0,      32'h3010);
      tv[9]  = mk(6'h00, N, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, Y, 32'h0,      32'h1000);
      tv[10] = mk(6'h00, Y, 32'h3014,   N, 6'd0,  Y, N, 5'd12, 32'h0,         N, Y, Y, 32'h3010,   32'h0000_fc03);
      tv[11] = mk(6'h00, Y, 32'h3024,   Y, 6'd10, N, N, 5'd13, 32'h0,         Y, N, N, HPC,        32'h0);
      tv[12] = mk(6'h00, Y, 32'h3028,   N, 6'd12, N, N, 5'd13, 32'h0,         N, N, Y, 32'h0,      32'h8000_0028);
      tv[13] = mk(6'h00, N, 32'h0,      N, 6'd0,  N, N, 5'd14, 32'h0,         N, N, Y, 32'h0,      32'h3020);
      tv[14] = mk(6'h00, Y, 32'h302c,   N, 6'd0,  Y, N, 5'd14, 32'h0,         N, Y, Y, 32'h3020,   32'h3020);
      tv[15] = mk(6'h01, N, 32'h0,      N, 6'd0,  Y, N, 5'd12, 32'h0,         N, N, N, 32'h0,      32'h0000_fc01);
      tv[16] = mk(6'h01, Y, 32'h3030,   N, 6'd0,  Y, N, 5'd14, 32'h0,         N, Y, N, 32'h3020,   32'h3020);
      tv[17] = mk(6'h01, Y, 32'h3040,   N, 6'd12, N, Y, 5'd14, 32'hdead_beef, Y, N, N, HPC,        32'h3020);
      tv[18] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd14, 32'h0,         N, N, Y, 32'h0,      32'h3040);
      tv[19] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, Y, 32'h0,      32'h0400);
      tv[20] = mk(6'h01, Y, 32'h3044,   N, 6'd0,  Y, Y, 5'd14, 32'h3007,      N, Y, Y, 32'h3040,   32'h3040);
      tv[21] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd14, 32'h0,         N, N, N, 32'h0,      32'h3004);
      tv[22] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd12, 32'h0,         N, N, N, 32'h0,      32'h0000_fc01);
      tv[23] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd13, 32'h0,         N, N, N, 32'h0,      32'h0400);
      tv[24] = mk(6'h01, Y, 32'h3050,   N, 6'd0,  N, N, 5'd14, 32'h0,         Y, N, N, HPC,        32'h3004);
      tv[25] = mk(6'h01, Y, 32'h3054,   N, 6'd0,  N, N, 5'd14, 32'h0,         N, N, Y, 32'h0,      32'h3050);
      tv[26] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, Y, 5'd12, 32'h0401,      N, N, Y, 32'h0,      32'h0000_fc03);
      tv[27] = mk(6'h01, N, 32'h0,      N, 6'd0,  N, N, 5'd12, 32'h0,         N, N, N, 32'h0,      32'h0000_0401);

      // held in reset with every input trying to provoke a trap or a write
      reset     = 1'b0;
      hw_int    = 6'h3f;
      m_valid   = 1'b1;
      pc_m      = 32'h3000;
      bd_m      = 1'b0;
      exccode_m = 6'd10;
      eret_m    = 1'b1;
      cp0_we    = 1'b1;
      cp0_addr  = 5'd13;
      cp0_wdata = 32'hffff_ffff;
      model_reset();
      step("reset_hold0", 1'b1, {3'b000, 32'd0, 32'd0});
      step("reset_hold1", 1'b1, {3'b000, 32'd0, 32'd0});
      cp0_addr = 5'd15;
      step("reset_prid", 1'b1, {3'b000, 32'd0, PRID});
      reset = 1'b1;

      for (int i = 0; i < 28; i++) begin
         hw_int    = tv[i].hw;
         m_valid   = tv[i].mv;
         pc_m      = tv[i].pc;
         bd_m      = tv[i].bd;
         exccode_m = tv[i].exc;
         eret_m    = tv[i].eret;
         cp0_we    = tv[i].we;
         cp0_addr  = tv[i].addr;
         cp0_wdata = tv[i].wd;
         step($sformatf("vec%0d", i), 1'b1, {tv[i].fl, tv[i].er, tv[i].exl, tv[i].rpc, tv[i].rd});
      end

      // interrupt trapping, then reset pulled low in the middle of that cycle
      hw_int    = 6'h01;
      m_valid   = 1'b1;
      pc_m      = 32'h3060;
      exccode_m = 6'd0;
      eret_m    = 1'b0;
      cp0_we    = 1'b0;
      cp0_addr  = 5'd12;
      #2;
      check("irq_before_reset", outs(), {3'b100, HPC, 32'h0000_0401});
      reset = 1'b0;
      #1;
      check("reset_drops_flush", outs(), {3'b000, 32'd0, 32'd0});
      cp0_addr = 5'd14;
      #1;
      check("reset_clears_epc", outs(), {3'b000, 32'd0, 32'd0});
      cp0_addr = 5'd15;
      #1;
      check("reset_prid_mid", outs(), {3'b000, 32'd0, PRID});
      @(posedge clk);
      #1;
      model_reset();
      reset = 1'b1;

      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 3) == 0) hw_int = 6'($urandom);
         m_valid   = ($urandom_range(0, 3) != 0);
         pc_m      = $urandom;
         bd_m      = 1'($urandom);
         exccode_m = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
         eret_m    = ($urandom_range(0, 6) == 0);
         cp0_we    = ($urandom_range(0, 3) == 0);
         cp0_addr  = 5'($urandom_range(10, 17));
         cp0_wdata = $urandom;
         reset     = ((c % 500) != 499);
         step($sformatf("rand%0d", c), 1'b0, 67'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
